// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divider: operation encodings, FSM states
// and the fixed results of the two RISC-V division corner cases.
package div_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] SIGNED_OVF    = {1'b1, {(XLEN-1){1'b0}}};

    // Encoding places the signedness in bit 0 (inverted) and quotient/remainder in bit 1.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage divider request/response bundle; the issue side is the master,
// the divider is the slave.
interface div_unit_if import div_unit_pkg::*; #(
    parameter int DATA_W = XLEN
);
    logic              start_i;
    logic [1:0]        op_i;
    logic [DATA_W-1:0] dividend_i;
    logic [DATA_W-1:0] divisor_i;
    logic [4:0]        rd_addr_i;
    logic              abort_i;
    logic [DATA_W-1:0] result_o;
    logic              ready_o;
    logic              we_o;
    logic [4:0]        rd_addr_o;
    logic              busy_o;
    logic              hold_flag_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, rd_addr_i, abort_i,
        input  result_o, ready_o, we_o, rd_addr_o, busy_o, hold_flag_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, abort_i,
        output result_o, ready_o, we_o, rd_addr_o, busy_o, hold_flag_o
    );
endinterface

// File: rtl/div_unit_iter.sv
// One radix-2 restoring step: bring down the next dividend bit, trial-subtract
// the divisor and shift the resulting quotient bit into the dividend register.
module div_unit_iter import div_unit_pkg::*; #(
    parameter int DATA_W = XLEN
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] dvs,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);
    logic [DATA_W:0] partial;
    logic [DATA_W:0] diff;
    logic            ge;

    // The remainder can use its full width, so the trial subtract is one bit wider.
    assign partial  = {rem, quo[DATA_W-1]};
    assign diff     = partial - {1'b0, dvs};
    assign ge       = ~diff[DATA_W];
    assign rem_next = ge ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    assign quo_next = {quo[DATA_W-2:0], ge};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle,
// stalling the front of the pipeline through hold_flag_o while it works.
module div_unit import div_unit_pkg::*; #(
    parameter int DATA_W = XLEN
) (
    input logic       clk,
    input logic       rst_n,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    div_state_e        state_q, state_d;
    logic [1:0]        op_q;
    logic              q_neg_q, r_neg_q;
    logic [DATA_W-1:0] quo_q, dvs_q, rem_q, result_q;
    logic [4:0]        rd_q, rd_out_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, signed_op, a_neg, b_neg;
    logic              div_zero, div_ovf;
    logic [DATA_W-1:0] a_abs, b_abs, special_res;
    logic [DATA_W-1:0] rem_nx, quo_nx, fixed_q, fixed_r, fixed_res;

    assign accept    = (state_q == IDLE) && bus.start_i && !bus.abort_i;
    assign signed_op = op_is_signed(bus.op_i);
    assign a_neg     = signed_op && bus.dividend_i[DATA_W-1];
    assign b_neg     = signed_op && bus.divisor_i[DATA_W-1];
    assign a_abs     = a_neg ? -bus.dividend_i : bus.dividend_i;
    assign b_abs     = b_neg ? -bus.divisor_i : bus.divisor_i;
    assign div_zero  = (bus.divisor_i == '0);
    assign div_ovf   = signed_op && (bus.dividend_i == SIGNED_OVF) && (bus.divisor_i == '1);

    assign special_res = op_is_rem(bus.op_i) ? (div_zero ? bus.dividend_i : '0)
                                             : (div_zero ? DIV_BY_ZERO_Q : SIGNED_OVF);

    div_unit_iter #(.DATA_W(DATA_W)) u_iter (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvs      (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    assign fixed_q   = q_neg_q ? -quo_nx : quo_nx;
    assign fixed_r   = r_neg_q ? -rem_nx : rem_nx;
    assign fixed_res = op_is_rem(op_q) ? fixed_r : fixed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal assigned in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (div_zero || div_ovf) ? DONE : CALC;
            CALC: begin
                if (bus.abort_i)      state_d = IDLE;
                else if (cnt_q == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q    <= bus.op_i;
                    rd_q    <= bus.rd_addr_i;
                    q_neg_q <= a_neg ^ b_neg;
                    r_neg_q <= a_neg;
                    if (div_zero || div_ovf) begin
                        result_q <= special_res;
                        rd_out_q <= bus.rd_addr_i;
                    end else begin
                        rem_q <= '0;
                        quo_q <= a_abs;
                        dvs_q <= b_abs;
                        cnt_q <= CNT_W'(DATA_W - 1);
                    end
                end
                CALC: if (!bus.abort_i) begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt_q == '0) begin
                        result_q <= fixed_res;
                        rd_out_q <= rd_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stall gating on rst_n keeps the pipeline free while the core is held in reset.
    assign bus.hold_flag_o = rst_n && (accept || (state_q == CALC));
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.ready_o     = (state_q == DONE) && !bus.abort_i;
    assign bus.we_o        = bus.ready_o;
    assign bus.result_o    = result_q;
    assign bus.rd_addr_o   = rd_out_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, sign fix-up, corner cases,
// abort, busy-start rejection and mid-operation reset.
module tb_div_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    div_unit_if #(.DATA_W(32)) dif();

    div_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        dif.start_i    = 1'b0;
        dif.abort_i    = 1'b0;
        dif.op_i       = 2'd0;
        dif.dividend_i = '0;
        dif.divisor_i  = '0;
        dif.rd_addr_i  = '0;
    endtask

    // Issues one op in the current cycle (called #1 after a rising edge) and
    // records the cycle offset of ready_o, the result and the stall cycles.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic [31:0] res,
                          output logic [4:0] rd_out, output int holds, output logic we);
        dif.op_i = op; dif.dividend_i = a; dif.divisor_i = b; dif.rd_addr_i = rd;
        dif.start_i = 1'b1;
        lat = -1; holds = 0; res = 'x; rd_out = 'x; we = 1'b0;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            @(negedge clk);
            if (dif.hold_flag_o) holds++;
            if (dif.ready_o) begin
                lat = c; res = dif.result_o; rd_out = dif.rd_addr_o; we = dif.we_o;
            end
            @(posedge clk); #1;
            dif.start_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        dif.start_i = 1'b1;
        #2;
        n_checks++; if (dif.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", dif.busy_o); end
        n_checks++; if (dif.hold_flag_o !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", dif.hold_flag_o); end
        n_checks++; if ({dif.ready_o, dif.we_o} !== 2'b00) begin n_fail++; $display("FAIL reset_ready_we: got %b want 00", {dif.ready_o, dif.we_o}); end
        n_checks++; if (dif.result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", dif.result_o); end
        n_checks++; if (dif.rd_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", dif.rd_addr_o); end
        dif.start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int lat, holds; logic [31:0] res; logic [4:0] rd; logic we;
        run_op(2'd1, 32'd100, 32'd7, 5'd5, lat, res, rd, holds, we);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d want 33", lat); end
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_100_7: got %h want %h", res, 32'd14); end
        n_checks++; if (rd !== 5'd5) begin n_fail++; $display("FAIL divu_rd: got %0d want 5", rd); end
        n_checks++; if (holds !== 33) begin n_fail++; $display("FAIL divu_hold_cycles: got %0d want 33", holds); end
        n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL divu_we: got %b want 1", we); end
        run_op(2'd3, 32'd100, 32'd7, 5'd6, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu_100_7: got %h want %h", res, 32'd2); end
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd7, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'd1) begin n_fail++; $display("FAIL divu_wide: got %h want 1", res); end
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd8, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'd1) begin n_fail++; $display("FAIL remu_wide: got %h want 1", res); end
        repeat (3) @(negedge clk);
        n_checks++; if ({dif.result_o, dif.rd_addr_o} !== {32'd1, 5'd8}) begin n_fail++; $display("FAIL result_hold: got %h/%0d want 1/8", dif.result_o, dif.rd_addr_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        int lat, holds; logic [31:0] res; logic [4:0] rd; logic we;
        run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2: got %h want fffffffd", res); end
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2: got %h want ffffffff", res); end
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 5'd1, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'd1) begin n_fail++; $display("FAIL rem_7_m2: got %h want 1", res); end
        run_op(2'd0, 32'd7, 32'hFFFF_FFFE, 5'd1, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2: got %h want fffffffd", res); end
        run_op(2'd0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd1, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL div_m100_m7: got %h want e", res); end
        run_op(2'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd1, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rem_m100_m7: got %h want fffffffe", res); end
    endtask

    task automatic test_div_zero();
        int lat, holds; logic [31:0] res; logic [4:0] rd; logic we;
        run_op(2'd1, 32'd5, 32'd0, 5'd10, lat, res, rd, holds, we);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divz_latency: got %0d want 1", lat); end
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_5_0: got %h want ffffffff", res); end
        n_checks++; if (holds !== 1) begin n_fail++; $display("FAIL divz_hold_cycles: got %0d want 1", holds); end
        n_checks++; if (rd !== 5'd10) begin n_fail++; $display("FAIL divz_rd: got %0d want 10", rd); end
        run_op(2'd3, 32'd5, 32'd0, 5'd11, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'd5) begin n_fail++; $display("FAIL remu_5_0: got %h want 5", res); end
        run_op(2'd0, 32'hFFFF_FFFB, 32'd0, 5'd12, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_m5_0: got %h want ffffffff", res); end
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 5'd13, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL rem_m5_0: got %h want fffffffb", res); end
    endtask

    task automatic test_overflow();
        int lat, holds; logic [31:0] res; logic [4:0] rd; logic we;
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, lat, res, rd, holds, we);
        n_checks++; if ({lat, res} !== {32'd1, 32'h8000_0000}) begin n_fail++; $display("FAIL div_ovf: got lat %0d res %h want 1/80000000", lat, res); end
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, lat, res, rd, holds, we);
        n_checks++; if ({lat, res} !== {32'd1, 32'h0}) begin n_fail++; $display("FAIL rem_ovf: got lat %0d res %h want 1/0", lat, res); end
        run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, lat, res, rd, holds, we);
        n_checks++; if ({lat, res} !== {32'd33, 32'h0}) begin n_fail++; $display("FAIL divu_ovf_ops: got lat %0d res %h want 33/0", lat, res); end
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, lat, res, rd, holds, we);
        n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL remu_ovf_ops: got %h want 80000000", res); end
    endtask

    task automatic test_abort();
        int first_ready = -1; logic [31:0] rval = '0; logic [4:0] rdval = '0; int readies = 0;
        dif.op_i = 2'd1; dif.dividend_i = 32'd100; dif.divisor_i = 32'd7; dif.rd_addr_i = 5'd4;
        for (int c = 0; c <= 50; c++) begin
            dif.start_i = (c == 0 || c == 5 || c == 12);
            dif.abort_i = (c == 10);
            if (c == 5) begin dif.dividend_i = 32'd77; dif.divisor_i = 32'd3; end
            if (c == 12) begin dif.dividend_i = 32'd1000; dif.divisor_i = 32'd10; dif.rd_addr_i = 5'd9; end
            @(negedge clk);
            if (c == 11) begin
                n_checks++; if ({dif.busy_o, dif.hold_flag_o} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: busy/hold %b want 00", {dif.busy_o, dif.hold_flag_o}); end
            end
            if (dif.ready_o && first_ready < 0) begin first_ready = c; rval = dif.result_o; rdval = dif.rd_addr_o; end
            @(posedge clk); #1;
        end
        dif.start_i = 1'b0; dif.abort_i = 1'b0;
        n_checks++; if (first_ready !== 45) begin n_fail++; $display("FAIL abort_restart_latency: got %0d want 45", first_ready); end
        n_checks++; if ({rval, rdval} !== {32'd100, 5'd9}) begin n_fail++; $display("FAIL abort_restart_result: got %h/%0d want 64/9", rval, rdval); end

        // Abort during the DONE cycle of a divide-by-zero.
        dif.op_i = 2'd1; dif.dividend_i = 32'd5; dif.divisor_i = 32'd0; dif.rd_addr_i = 5'd2;
        dif.start_i = 1'b1;
        @(posedge clk); #1;
        dif.start_i = 1'b0; dif.abort_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({dif.ready_o, dif.we_o} !== 2'b00) begin n_fail++; $display("FAIL abort_done: ready/we %b want 00", {dif.ready_o, dif.we_o}); end
        @(posedge clk); #1;
        dif.abort_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); if (dif.ready_o) readies++;
            @(posedge clk); #1;
        end
        n_checks++; if (readies !== 0) begin n_fail++; $display("FAIL abort_done_late_ready: got %0d pulses want 0", readies); end

        // Abort beats start in IDLE.
        dif.start_i = 1'b1; dif.abort_i = 1'b1;
        @(negedge clk);
        n_checks++; if (dif.hold_flag_o !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start_hold: got %b want 0", dif.hold_flag_o); end
        @(posedge clk); #1;
        dif.start_i = 1'b0; dif.abort_i = 1'b0;
        @(negedge clk);
        n_checks++; if (dif.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start_busy: got %b want 0", dif.busy_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_in_done();
        dif.op_i = 2'd1; dif.dividend_i = 32'd5; dif.divisor_i = 32'd0; dif.rd_addr_i = 5'd21;
        dif.start_i = 1'b1;
        @(posedge clk); #1;
        dif.dividend_i = 32'd50; dif.divisor_i = 32'd5;
        @(negedge clk);
        n_checks++; if ({dif.ready_o, dif.result_o} !== {1'b1, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL done_cycle: ready %b result %h want 1/ffffffff", dif.ready_o, dif.result_o); end
        @(posedge clk); #1;
        dif.start_i = 1'b0;
        @(negedge clk);
        n_checks++; if (dif.busy_o !== 1'b0) begin n_fail++; $display("FAIL start_in_done_ignored: busy %b want 0", dif.busy_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, holds; logic [31:0] res; logic [4:0] rd; logic we;
        dif.op_i = 2'd1; dif.dividend_i = 32'd100; dif.divisor_i = 32'd7; dif.rd_addr_i = 5'd3;
        dif.start_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            dif.start_i = 1'b0;
        end
        n_checks++; if (dif.busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_live: busy %b want 1", dif.busy_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({dif.busy_o, dif.hold_flag_o, dif.ready_o, dif.we_o, dif.result_o, dif.rd_addr_o} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: busy %b hold %b ready %b we %b result %h rd %0d want all 0",
                               dif.busy_o, dif.hold_flag_o, dif.ready_o, dif.we_o, dif.result_o, dif.rd_addr_o);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'd1, 32'd9, 32'd3, 5'd17, lat, res, rd, holds, we);
        n_checks++; if ({lat, res, rd} !== {32'd33, 32'd3, 5'd17}) begin n_fail++; $display("FAIL post_reset_divu: got lat %0d res %h rd %0d want 33/3/17", lat, res, rd); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_start_in_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
